dcache_meta_array: RTL

Single-way L1 data-cache metadata (tag/coherence) store, directly downstream of the metadata request arbiter. Consumes one arbitrated read-or-write request per cycle; writes update the addressed set, reads return that set's 22-bit metadata one cycle later. After reset and on `io_flush`, a built-in walker clears every set before requests are accepted.

---
 rtl/dcache_meta_pkg.sv | 40 ++++
 rtl/dcache_meta_sram.sv | 37 +++
 rtl/dcache_meta_array.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dcache_meta_pkg.sv
// dcache_meta_pkg
// Shared constants and types for the single-way L1 data-cache metadata store.
// Sizes the array, carries the value the clear walker writes, and defines the
// two-state walker/ready FSM plus the request and response record layouts.
package dcache_meta_pkg;

  localparam int NSETS  = 64;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 22;
  localparam int ADDR_W = 40;

  // Invalid coherence state with a zero tag.
  localparam logic [DATA_W-1:0] INIT_VALUE = 22'h0;

  // Last set visited by the walker, and the walker step.
  localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;
  localparam logic [IDX_W-1:0] IDX_ONE  = 6'd1;
  localparam logic [IDX_W-1:0] IDX_ZERO = 6'd0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } meta_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } meta_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } meta_resp_t;

  localparam meta_resp_t RESP_ZERO = {(ADDR_W + IDX_W + DATA_W){1'b0}};

endpackage

// File: rtl/dcache_meta_sram.sv
// dcache_meta_sram
// NSETS x DATA_W single-port array with write enable and a registered
// (synchronous) read port. Behavioural stand-in for a hard macro.
// Ports:
//   clk    clock
//   we     write enable: mem[addr] <= wdata at the edge
//   re     read enable: rdata <= mem[addr] at the edge
//   addr   set index
//   wdata  write data
//   rdata  read data, held until the next read
module dcache_meta_sram
  import dcache_meta_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [NSETS];
  logic [DATA_W-1:0] rdata_r;

  // Array write and registered read; a read returns data written on an earlier edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dcache_meta_array.sv
// dcache_meta_array
// Single-way L1 data-cache metadata store. After reset or a flush a walker
// writes INIT_VALUE into every set (one per cycle); only then are arbitrated
// requests accepted. Writes update the addressed set; reads return the set's
// metadata one cycle after acceptance, together with the request idx/addr.
// Ports:
//   clock, reset               clock; synchronous active-low reset
//   io_req_valid/ready         request handshake (ready low while clearing/flushing)
//   io_req_bits_write/addr/idx/data  request fields
//   io_flush                   restart the clear walker
//   io_resp_valid              read response present this cycle
//   io_resp_bits_idx/addr/data response fields, held between reads
//   io_init_done               array cleared, requests accepted
module dcache_meta_array
  import dcache_meta_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_bits_write,
  input  logic [ADDR_W-1:0] io_req_bits_addr,
  input  logic [IDX_W-1:0]  io_req_bits_idx,
  input  logic [DATA_W-1:0] io_req_bits_data,
  input  logic              io_flush,
  output logic              io_resp_valid,
  output logic [IDX_W-1:0]  io_resp_bits_idx,
  output logic [ADDR_W-1:0] io_resp_bits_addr,
  output logic [DATA_W-1:0] io_resp_bits_data,
  output logic              io_init_done
);

  meta_state_t       state_r;
  meta_state_t       state_next_s;
  logic [IDX_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  cnt_next_s;

  meta_req_t         req_s;
  logic              ready_s;
  logic              sram_we_s;
  logic              sram_re_s;
  logic [IDX_W-1:0]  sram_addr_s;
  logic [DATA_W-1:0] sram_wdata_s;
  logic [DATA_W-1:0] sram_rdata_s;

  logic              resp_valid_r;
  meta_resp_t        resp_r;

  assign req_s = '{write: io_req_bits_write,
                   addr:  io_req_bits_addr,
                   idx:   io_req_bits_idx,
                   data:  io_req_bits_data};

  // FSM state and walk counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= CLEAR;
      cnt_r   <= IDX_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next state: walk every set once, restart on flush, leave after the last set.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (io_flush) begin
          cnt_next_s = IDX_ZERO;
        end else if (cnt_r == LAST_IDX) begin
          state_next_s = READY;
          cnt_next_s   = IDX_ZERO;
        end else begin
          cnt_next_s = cnt_r + IDX_ONE;
        end
      end
      READY: begin
        if (io_flush) begin
          state_next_s = CLEAR;
          cnt_next_s   = IDX_ZERO;
        end else begin
          state_next_s = READY;
        end
      end
      default: begin
        state_next_s = CLEAR;
        cnt_next_s   = IDX_ZERO;
      end
    endcase
  end

  // Port muxing: the walker owns the array in CLEAR, the request port in READY.
  // Array enables are gated by reset so a reset edge never disturbs contents
  // or launches a read.
  always_comb begin
    ready_s      = 1'b0;
    sram_we_s    = 1'b0;
    sram_re_s    = 1'b0;
    sram_addr_s  = cnt_r;
    sram_wdata_s = INIT_VALUE;
    case (state_r)
      CLEAR: begin
        ready_s      = 1'b0;
        sram_we_s    = reset;
        sram_addr_s  = cnt_r;
        sram_wdata_s = INIT_VALUE;
      end
      READY: begin
        ready_s      = !io_flush;
        sram_we_s    = reset & io_req_valid & ready_s & req_s.write;
        sram_re_s    = reset & io_req_valid & ready_s & !req_s.write;
        sram_addr_s  = req_s.idx;
        sram_wdata_s = req_s.data;
      end
      default: begin
        ready_s   = 1'b0;
        sram_we_s = 1'b0;
        sram_re_s = 1'b0;
      end
    endcase
  end

  dcache_meta_sram u_sram (
    .clk   (clock),
    .we    (sram_we_s),
    .re    (sram_re_s),
    .addr  (sram_addr_s),
    .wdata (sram_wdata_s),
    .rdata (sram_rdata_s)
  );

  // Response registers. The array output is live only in the response cycle;
  // it is captured at the end of that cycle so the data holds afterwards and
  // reads back as zero after reset regardless of the array's output register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_valid_r <= 1'b0;
      resp_r       <= RESP_ZERO;
    end else begin
      resp_valid_r <= sram_re_s;
      if (sram_re_s) begin
        resp_r.addr <= req_s.addr;
        resp_r.idx  <= req_s.idx;
      end
      if (resp_valid_r) begin
        resp_r.data <= sram_rdata_s;
      end
    end
  end

  assign io_req_ready      = ready_s;
  assign io_init_done      = (state_r == READY);
  assign io_resp_valid     = resp_valid_r;
  assign io_resp_bits_idx  = resp_r.idx;
  assign io_resp_bits_addr = resp_r.addr;
  assign io_resp_bits_data = resp_valid_r ? sram_rdata_s : resp_r.data;

endmodule
